tx_pingpong_sched: RTL

Scheduler for the double-buffered I2C transmit path. It accepts a host byte stream and steers each byte into whichever TX buffer (0 or 1) is filling. It hands completed buffers, in order, to the TX controller for draining, and recycles each buffer once its bytes are acknowledged. It sits between the host write interface and the TX controller / TX buffer pair.

---
 rtl/tx_pingpong_sched.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tx_pingpong_sched.sv
// ----------------------------------------------------------------------------
// tx_pingpong_sched
//
// Purpose:
//   Scheduler for the double-buffered I2C transmit path. Host bytes are
//   steered into whichever of the two TX buffers is currently filling.
//   Completed buffers are handed to the TX controller strictly in fill order,
//   and each buffer is recycled once the controller reports that its bytes
//   were acknowledged. A NACK during a drain flushes everything and raises a
//   sticky error that only a low pulse on enable clears.
//
// Optional feature macro:
//   TXSCHED_WATCHDOG_EN - builds a drain watchdog. If a buffer stays in
//   DRAINING for WDOG_CYCLES cycles without drain_done/drain_nack, the
//   scheduler flushes as for a NACK and raises err_timeout instead. Without
//   the macro no counter exists and err_timeout is constant low.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   enable                  transfer enable; low flushes to idle on next edge
//   host_valid/data/last    host byte stream (last marks end of transfer)
//   host_ready              byte can be accepted this cycle
//   load_buf0/load_buf1     one-cycle write strobe into TX buffer 0/1
//   load_data/load_idx      registered byte and its slot in the strobed buffer
//   drain_req/sel/len/last  full buffer ready for the TX controller
//   drain_ack               TX controller took the drain request
//   drain_done              all bytes of the draining buffer were ACKed
//   drain_nack              slave NACK during drain
//   busy                    some buffer is not EMPTY
//   err_nack, err_timeout   sticky error flags
// ----------------------------------------------------------------------------
module tx_pingpong_sched #(
    parameter int BYTES_PER_BUF = 2,
    parameter int CNT_W         = 3,
    parameter int WDOG_CYCLES   = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             host_valid,
    input  logic [7:0]       host_data,
    input  logic             host_last,
    output logic             host_ready,
    output logic             load_buf0,
    output logic             load_buf1,
    output logic [7:0]       load_data,
    output logic [CNT_W-1:0] load_idx,
    output logic             drain_req,
    output logic             drain_sel,
    output logic [CNT_W-1:0] drain_len,
    output logic             drain_last,
    input  logic             drain_ack,
    input  logic             drain_done,
    input  logic             drain_nack,
    output logic             busy,
    output logic             err_nack,
    output logic             err_timeout
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } buf_state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_BUF - 1);

    // Per-buffer bookkeeping, indexed by buffer number
    buf_state_t       st_q   [2];
    buf_state_t       st_d   [2];
    logic [CNT_W-1:0] cnt_q  [2];
    logic [CNT_W-1:0] cnt_d  [2];
    logic [CNT_W-1:0] len_q  [2];
    logic [CNT_W-1:0] len_d  [2];
    logic             last_q [2];
    logic             last_d [2];

    logic             fp_q, fp_d;
    logic             dp_q, dp_d;
    logic             err_nack_q, err_nack_d;
    logic             err_to_q;
    logic             out_of_reset_q;

    logic             load0_d, load1_d;
    logic [7:0]       ldata_d;
    logic [CNT_W-1:0] lidx_d;

    logic             any_draining;
    logic             dp_draining;
    logic             nack_hit;
    logic             wdog_fire;
    logic             flush;
    logic             accept;

    // Only the buffer at dp can ever be draining; any_draining gates new
    // drain requests, dp_draining qualifies the completion/NACK inputs.
    assign any_draining = (st_q[0] == DRAINING) || (st_q[1] == DRAINING);
    assign dp_draining  = (st_q[dp_q] == DRAINING);
    assign nack_hit     = dp_draining && drain_nack;
    assign flush        = !enable || nack_hit || wdog_fire;
    assign accept       = host_valid && host_ready;

`ifdef TXSCHED_WATCHDOG_EN
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q;

    // A drain_done or drain_nack on the terminal cycle takes precedence
    // over the timeout.
    assign wdog_fire = enable && dp_draining && (wdog_q == WDOG_LIMIT)
                       && !drain_done && !drain_nack;

    // Watchdog counter: zero whenever the drain pointer's buffer is not
    // draining, so it starts from zero on every entry into DRAINING.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q   <= '0;
            err_to_q <= 1'b0;
        end else begin
            if (!enable || !dp_draining || wdog_fire)
                wdog_q <= '0;
            else
                wdog_q <= wdog_q + 1'b1;

            if (!enable)
                err_to_q <= 1'b0;
            else if (wdog_fire)
                err_to_q <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
    // Constant low in this build; the comparison is always false.
    assign err_to_q  = (WDOG_CYCLES < 0);
`endif

    // State register: all scheduler state plus the registered load strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0]        <= EMPTY;
            st_q[1]        <= EMPTY;
            cnt_q[0]       <= '0;
            cnt_q[1]       <= '0;
            len_q[0]       <= '0;
            len_q[1]       <= '0;
            last_q[0]      <= 1'b0;
            last_q[1]      <= 1'b0;
            fp_q           <= 1'b0;
            dp_q           <= 1'b0;
            err_nack_q     <= 1'b0;
            out_of_reset_q <= 1'b0;
            load_buf0      <= 1'b0;
            load_buf1      <= 1'b0;
            load_data      <= '0;
            load_idx       <= '0;
        end else begin
            st_q[0]        <= st_d[0];
            st_q[1]        <= st_d[1];
            cnt_q[0]       <= cnt_d[0];
            cnt_q[1]       <= cnt_d[1];
            len_q[0]       <= len_d[0];
            len_q[1]       <= len_d[1];
            last_q[0]      <= last_d[0];
            last_q[1]      <= last_d[1];
            fp_q           <= fp_d;
            dp_q           <= dp_d;
            err_nack_q     <= err_nack_d;
            out_of_reset_q <= 1'b1;
            load_buf0      <= load0_d;
            load_buf1      <= load1_d;
            load_data      <= ldata_d;
            load_idx       <= lidx_d;
        end
    end

    // Next-state logic. A flush (enable low, NACK or watchdog) overrides
    // every other event in the cycle, including a host accept whose byte is
    // dropped. Otherwise host accept, drain issue and drain completion all
    // apply together; they never touch the same buffer in the same cycle.
    always_comb begin
        st_d[0]    = st_q[0];
        st_d[1]    = st_q[1];
        cnt_d[0]   = cnt_q[0];
        cnt_d[1]   = cnt_q[1];
        len_d[0]   = len_q[0];
        len_d[1]   = len_q[1];
        last_d[0]  = last_q[0];
        last_d[1]  = last_q[1];
        fp_d       = fp_q;
        dp_d       = dp_q;
        load0_d    = 1'b0;
        load1_d    = 1'b0;
        ldata_d    = load_data;
        lidx_d     = load_idx;
        err_nack_d = enable && (err_nack_q || nack_hit);

        if (flush) begin
            st_d[0]   = EMPTY;
            st_d[1]   = EMPTY;
            cnt_d[0]  = '0;
            cnt_d[1]  = '0;
            len_d[0]  = '0;
            len_d[1]  = '0;
            last_d[0] = 1'b0;
            last_d[1] = 1'b0;
            fp_d      = 1'b0;
            dp_d      = 1'b0;
            ldata_d   = '0;
            lidx_d    = '0;
        end else begin
            if (accept) begin
                load0_d       = !fp_q;
                load1_d       = fp_q;
                ldata_d       = host_data;
                lidx_d        = cnt_q[fp_q];
                cnt_d[fp_q]   = cnt_q[fp_q] + 1'b1;
                st_d[fp_q]    = FILLING;
                // Buffer closes on its last slot or on the transfer's last
                // byte; filling moves to the other buffer from a clean count.
                if ((cnt_q[fp_q] == LAST_IDX) || host_last) begin
                    st_d[fp_q]   = FULL;
                    len_d[fp_q]  = cnt_q[fp_q] + 1'b1;
                    last_d[fp_q] = host_last;
                    fp_d         = !fp_q;
                    cnt_d[!fp_q] = '0;
                end
            end

            if (drain_req && drain_ack)
                st_d[dp_q] = DRAINING;

            if (dp_draining && drain_done) begin
                st_d[dp_q] = EMPTY;
                dp_d       = !dp_q;
            end
        end
    end

    // Outputs derived from registered state only. out_of_reset_q keeps
    // host_ready low while rst_n is asserted regardless of enable.
    always_comb begin
        host_ready  = out_of_reset_q && enable && !err_nack_q && !err_to_q
                      && ((st_q[fp_q] == EMPTY) || (st_q[fp_q] == FILLING));
        drain_req   = !any_draining && (st_q[dp_q] == FULL);
        drain_sel   = drain_req && dp_q;
        drain_len   = drain_req ? len_q[dp_q] : '0;
        drain_last  = drain_req && last_q[dp_q];
        busy        = (st_q[0] != EMPTY) || (st_q[1] != EMPTY);
        err_nack    = err_nack_q;
        err_timeout = err_to_q;
    end

endmodule
